// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_t : sequencer state (IDLE, DATA, FETCH)
//   NOP_INSTR   : instruction returned to IF when a fetch is aborted
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// arb_watchdog
// Busy-cycle counter for the memory port. Cleared when a transaction
// starts, counts every busy cycle, and saturates once it reaches TIMEOUT.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart the count (new transaction entering this cycle)
//   en        : count this cycle (sequencer busy)
//   expired   : count has reached TIMEOUT
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  assign expired = (r_cnt == CW'(TIMEOUT));

  // Busy-cycle counter; holds at TIMEOUT so expired stays asserted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Sequencer for the single-ported instruction/data memory. Serves the MEM
// stage (loads/stores) ahead of the IF stage, drives the memory handshake
// with fields held stable for the whole transaction, returns read data with
// one-cycle ack pulses, raises pipeline stalls while a requester waits, and
// aborts transactions the memory never completes.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   if_req/if_addr -> if_ack/if_instr : instruction fetch port
//   d_rd/d_wr/d_addr/d_wdata/d_be     : load/store request
//   d_ack/d_rdata                     : load/store completion and load data
//   m_req/m_we/m_addr/m_wdata/m_be    : memory request (registered)
//   m_ready/m_rdata                   : memory completion and read data
//   stall_if, stall_mem               : pipeline freeze controls
//   bus_err                           : pulse on watchdog abort
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_instr,
  input  logic                d_rd,
  input  logic                d_wr,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INSTR);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                w_d_any;
  logic                w_busy;
  logic                w_expired;
  logic                w_finish;
  logic                w_abort;
  logic                w_enter;
  logic                r_m_req;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [BE_W-1:0]     r_m_be;
  logic                r_if_ack;
  logic [DATA_W-1:0]   r_if_instr;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_bus_err;

  assign w_d_any  = d_rd | d_wr;
  assign w_busy   = (r_state != IDLE);
  // A transaction ends on m_ready or when the watchdog runs out
  assign w_finish = w_busy & (m_ready | w_expired);
  assign w_abort  = w_busy & ~m_ready & w_expired;

  // Next-state selection; on completion only the other requester is considered
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_any) begin
          w_state_nxt = DATA;
        end else if (if_req) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (w_finish) begin
          w_state_nxt = if_req ? FETCH : IDLE;
        end else begin
          w_state_nxt = DATA;
        end
      end
      FETCH: begin
        if (w_finish) begin
          w_state_nxt = w_d_any ? DATA : IDLE;
        end else begin
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A new transaction starts from IDLE or back-to-back after a finish
  assign w_enter = (w_state_nxt != IDLE) & (~w_busy | w_finish);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_enter),
    .en      (w_busy),
    .expired (w_expired)
  );

  // State register and memory request fields, captured once at entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_be    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_m_req <= (w_state_nxt != IDLE);
      if (w_enter) begin
        if (w_state_nxt == DATA) begin
          // a simultaneous rd+wr is a store
          r_m_we    <= d_wr;
          r_m_addr  <= d_addr;
          r_m_wdata <= d_wdata;
          r_m_be    <= d_be;
        end else begin
          r_m_we    <= 1'b0;
          r_m_addr  <= if_addr;
          r_m_wdata <= '0;
          r_m_be    <= '1;
        end
      end else begin
        r_m_we    <= r_m_we;
        r_m_addr  <= r_m_addr;
        r_m_wdata <= r_m_wdata;
        r_m_be    <= r_m_be;
      end
    end
  end

  // Ack pulses, bus error pulse and returned data, one cycle after finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_if_instr <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_ack  <= w_finish & (r_state == FETCH);
      r_d_ack   <= w_finish & (r_state == DATA);
      r_bus_err <= w_abort;
      if (w_finish && (r_state == FETCH)) begin
        r_if_instr <= m_ready ? m_rdata : NOP_W;
      end else begin
        r_if_instr <= r_if_instr;
      end
      // stores leave the load data register untouched
      if (w_finish && (r_state == DATA) && !r_m_we) begin
        r_d_rdata <= m_ready ? m_rdata : '0;
      end else begin
        r_d_rdata <= r_d_rdata;
      end
    end
  end

  assign m_req     = r_m_req;
  assign m_we      = r_m_we;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign m_be      = r_m_be;
  assign if_ack    = r_if_ack;
  assign if_instr  = r_if_instr;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign bus_err   = r_bus_err;
  assign stall_if  = if_req & ~r_if_ack;
  assign stall_mem = w_d_any & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed cycle checks followed by randomized traffic from two requesters
// against a behavioural memory device. Expected responses are queued at
// request time and compared by a monitor whenever an ack appears.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_instr;
  logic        d_rd, d_wr;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        stall_if, stall_mem, bus_err;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } sb_t;

  sb_t if_q[$];
  sb_t d_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference memory and device memory are kept separately
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] last_drd = 32'h0;
  int          fixed_wait = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic is_bad(input logic [31:0] a);
    return (a[15:12] == 4'hF);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    dev_mem[a] = d;
  endtask

  // Memory device: random (or fixed) wait states, never answers bad region,
  // checks that request fields stay stable for a whole transaction.
  initial begin : device
    logic        active;
    int          cnt, wt;
    logic [31:0] cap_addr, cap_wdata;
    logic [4:0]  cap_ctl;
    logic [31:0] w;
    active  = 1'b0;
    cnt     = 0;
    wt      = 0;
    m_ready = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        active  = 1'b0;
        m_ready = 1'b0;
      end else begin
        if (active && (m_ready || cnt == TO + 1)) active = 1'b0;
        if (!active && m_req) begin
          active    = 1'b1;
          cnt       = 0;
          wt        = is_bad(m_addr) ? TO + 10 :
                      (fixed_wait >= 0 ? fixed_wait : int'($urandom_range(0, TO)));
          cap_addr  = m_addr;
          cap_wdata = m_wdata;
          cap_ctl   = {m_we, m_be};
        end else if (active) begin
          check("m_req_held", {63'h0, m_req}, 64'h1);
          check("m_addr_stable", {32'h0, m_addr}, {32'h0, cap_addr});
          check("m_fields_stable", {27'h0, m_we, m_be, m_wdata}, {27'h0, cap_ctl, cap_wdata});
        end
        if (active) begin
          m_ready = (cnt == wt);
          if (m_ready) begin
            w = dev_mem.exists(m_addr) ? dev_mem[m_addr] : init_word(m_addr);
            if (m_we) dev_mem[m_addr] = merge_be(w, m_wdata, m_be);
            m_rdata = w;
          end else begin
            m_rdata = $urandom;
          end
          cnt++;
        end else begin
          m_ready = 1'b0;
          m_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever an ack is presented
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (if_ack) begin
        if (if_q.size() == 0) fail_msg("if_ack_unexpected");
        else begin
          e = if_q.pop_front();
          check("if_instr", {32'h0, if_instr}, {32'h0, e.data});
          check("if_bus_err", {63'h0, bus_err}, {63'h0, e.err});
        end
      end
      if (d_ack) begin
        if (d_q.size() == 0) fail_msg("d_ack_unexpected");
        else begin
          e = d_q.pop_front();
          check("d_rdata", {32'h0, d_rdata}, {32'h0, e.data});
          check("d_bus_err", {63'h0, bus_err}, {63'h0, e.err});
        end
      end
      if (bus_err && !if_ack && !d_ack) fail_msg("bus_err_without_ack");
    end
  end

  // Global time limit
  initial begin : guard
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

  task automatic push_fetch(input logic [31:0] a);
    sb_t e;
    e.err  = is_bad(a);
    e.data = e.err ? NOP_INSTR : ref_rd(a);
    if_q.push_back(e);
  endtask

  // op: 0 load, 1 store, 2 load+store (store)
  task automatic push_data(input int op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
    sb_t e;
    e.err = is_bad(a);
    if (op == 0) begin
      last_drd = e.err ? 32'h0 : ref_rd(a);
    end else if (!e.err) begin
      ref_mem[a] = merge_be(ref_rd(a), wd, be);
    end
    e.data = last_drd;
    d_q.push_back(e);
  endtask

  task automatic if_driver(input int n);
    for (int k = 0; k < n; k++) begin
      int          gap, t;
      logic [31:0] a;
      gap = $urandom_range(1, 4);
      repeat (gap) tick();
      if ($urandom_range(0, 7) == 0) a = 32'h0000_F000 + 32'($urandom_range(0, 63) << 2);
      else a = 32'($urandom_range(0, 255) << 2);
      if_addr = a;
      if_req  = 1'b1;
      push_fetch(a);
      t = 0;
      do begin
        tick();
        t++;
      end while (!if_ack && t < 100);
      if (!if_ack) fail_msg("if_ack_timeout");
      if_req = 1'b0;
    end
  endtask

  task automatic d_driver(input int n);
    for (int k = 0; k < n; k++) begin
      int          gap, t, op;
      logic [31:0] a, wd;
      logic [3:0]  be;
      gap = $urandom_range(1, 4);
      repeat (gap) tick();
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) a = 32'h0000_F000 + 32'($urandom_range(0, 15) << 2);
      else a = 32'h0000_1000 + 32'($urandom_range(0, 15) << 2);
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      d_addr  = a;
      d_wdata = wd;
      d_be    = be;
      d_rd    = (op != 1);
      d_wr    = (op != 0);
      push_data(op, a, wd, be);
      t = 0;
      do begin
        tick();
        t++;
      end while (!d_ack && t < 100);
      if (!d_ack) fail_msg("d_ack_timeout");
      d_rd = 1'b0;
      d_wr = 1'b0;
    end
  endtask

  initial begin : main
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    repeat (2) tick();
    check("rst_m_req", {63'h0, m_req}, 64'h0);
    check("rst_outs", {58'h0, if_ack, d_ack, bus_err, stall_if, stall_mem, m_we}, 64'h0);
    check("rst_data", {if_instr, d_rdata}, 64'h0);
    rst = 1'b0;
    tick();

    // Fetch with zero wait states
    fixed_wait = 0;
    preload(32'h100, 32'h0050_0093);
    if_addr = 32'h100; if_req = 1'b1; push_fetch(32'h100);
    #1 check("t1_c0_stall_if", {63'h0, stall_if}, 64'h1);
    check("t1_c0_m_req", {63'h0, m_req}, 64'h0);
    tick();
    check("t1_c1_m_req", {63'h0, m_req}, 64'h1);
    check("t1_c1_fields", {27'h0, m_we, m_be, m_addr}, {27'h0, 1'b0, 4'hF, 32'h100});
    check("t1_c1_stall_if", {62'h0, stall_if, if_ack}, {62'h0, 2'b10});
    tick();
    check("t1_c2_ack", {62'h0, if_ack, stall_if}, {62'h0, 2'b10});
    check("t1_c2_instr", {32'h0, if_instr}, {32'h0, 32'h0050_0093});
    if_req = 1'b0;
    tick();
    check("t1_c3_idle", {62'h0, m_req, if_ack}, 64'h0);

    // Simultaneous load and fetch, data first, no bubble between them
    d_addr = 32'h200; d_rd = 1'b1; push_data(0, 32'h200, 32'h0, 4'h0);
    if_addr = 32'h104; if_req = 1'b1; push_fetch(32'h104);
    tick();
    check("t2_c1_data", {31'h0, m_req, m_we, m_addr}, {31'h0, 2'b10, 32'h200});
    check("t2_c1_stalls", {62'h0, stall_mem, stall_if}, {62'h0, 2'b11});
    tick();
    check("t2_c2_dack", {62'h0, d_ack, stall_mem}, {62'h0, 2'b10});
    check("t2_c2_fetch", {26'h0, m_req, m_we, m_be, m_addr}, {26'h0, 2'b10, 4'hF, 32'h104});
    d_rd = 1'b0;
    tick();
    check("t2_c3_ifack", {62'h0, if_ack, d_ack}, {62'h0, 2'b10});
    if_req = 1'b0;
    tick();
    check("t2_c4_idle", {63'h0, m_req}, 64'h0);

    // Store with three wait states
    fixed_wait = 3;
    d_addr = 32'h300; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; d_wr = 1'b1;
    push_data(1, 32'h300, 32'hDEAD_BEEF, 4'b0011);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("t3_busy_fields", {26'h0, m_req, m_we, m_be, m_addr},
            {26'h0, 2'b11, 4'b0011, 32'h300});
      check("t3_busy_noack", {62'h0, d_ack, stall_mem}, {62'h0, 2'b01});
    end
    tick();
    check("t3_c5_dack", {63'h0, d_ack}, 64'h1);
    check("t3_c5_rdata_kept", {32'h0, d_rdata}, {32'h0, init_word(32'h200)});
    d_wr = 1'b0;
    tick();

    // Fetch the memory never answers: watchdog abort
    if_addr = 32'h0000_F040; if_req = 1'b1; push_fetch(32'h0000_F040);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("t4_wait", {61'h0, m_req, if_ack, bus_err}, {61'h0, 3'b100});
    end
    tick();
    check("t4_c6_abort", {62'h0, if_ack, bus_err}, {62'h0, 2'b11});
    check("t4_c6_nop", {32'h0, if_instr}, {32'h0, NOP_INSTR});
    if_req = 1'b0;
    tick();

    // Reset while a load is waiting on memory
    d_addr = 32'h0000_F100; d_rd = 1'b1;
    repeat (2) tick();
    check("t5_busy", {63'h0, m_req}, 64'h1);
    #2 rst = 1'b1;
    #1 check("t5_req_drop", {63'h0, m_req}, 64'h0);
    d_rd = 1'b0;
    last_drd = 32'h0;
    repeat (2) tick();
    check("t5_no_ack", {62'h0, d_ack, if_ack}, 64'h0);
    rst = 1'b0;
    tick();
    check("t5_idle", {63'h0, m_req}, 64'h0);
    tick();

    // Randomized concurrent traffic
    fixed_wait = -1;
    fork
      if_driver(40);
      d_driver(40);
    join
    repeat (10) tick();
    check("if_q_drained", 64'(if_q.size()), 64'h0);
    check("d_q_drained", 64'(d_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller for the single-ported unified instruction/data memory of the pipelined core. Arbitrates between the IF stage (instruction fetch) and the MEM stage (load/store driven by the decoder's mr/mwrite), drives the memory handshake, returns read data, and generates the stall signals that freeze the pipeline while a requester waits. A watchdog aborts transactions the memory never completes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- TIMEOUT, 255, max cycles in a busy state before abort (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse: if_instr valid
- if_instr  out  DATA_W  fetched word, held until next if_ack
- d_rd, d_wr  in  1 each  load / store request, held until d_ack
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_ack  out  1  one-cycle pulse: access done, d_rdata valid for loads
- d_rdata  out  DATA_W  load word, held until next d_ack
- m_req, m_we  out  1 each  memory request / write enable
- m_addr, m_wdata, m_be  out  ADDR_W, DATA_W, DATA_W/8  memory request fields
- m_ready  in  1  memory completes current request this cycle
- m_rdata  in  DATA_W  read data, valid with m_ready
- stall_if  out  1  freeze PC and IF/ID
- stall_mem  out  1  freeze whole pipeline
- bus_err  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, DATA, FETCH. Reset: IDLE; all outputs 0; if_instr/d_rdata 0; watchdog 0.
- IDLE: if d_rd|d_wr → DATA; else if if_req → FETCH; else stay. Data always wins (older instruction).
- DATA/FETCH: m_req=1; m_addr/m_wdata/m_be/m_we registered at entry and held stable until exit. FETCH: m_we=0, m_be all ones. DATA: m_we=d_wr. d_rd&d_wr both high → treated as store.
- Completion (m_ready=1 in busy state): latch m_rdata into if_instr (FETCH) or d_rdata (DATA loads only; stores leave d_rdata unchanged); pulse matching ack next cycle.
- Next state on completion considers only the other requester (served one still holds its request): after DATA → FETCH if if_req else IDLE; after FETCH → DATA if d_rd|d_wr else IDLE. Back-to-back, no IDLE bubble.
- Watchdog counts cycles in a busy state, clears on entry. Reaching TIMEOUT without m_ready: abort, bus_err pulse, ack pulse with data 0x00000013 (NOP) for fetch or 0 for load, next state as for completion.
- stall_if = if_req & ~if_ack; stall_mem = (d_rd|d_wr) & ~d_ack (combinational).
- rst mid-transaction: m_req drops immediately, pending transaction discarded, no ack.

## Timing
- Request seen cycle 0 in IDLE → m_req high cycle 1 → m_ready earliest cycle 1 → ack cycle 2. Minimum latency 2 cycles; +N per memory wait cycle.
- Requester must drop its request in the ack cycle or it is re-served.
- m_req is deasserted the cycle after m_ready unless a back-to-back grant follows (fields change that cycle).
- Abort: ack and bus_err in cycle entry+TIMEOUT+1.

## Structure
- Shared package: arb_state_t enum (IDLE, DATA, FETCH), NOP_INSTR = 32'h00000013.
- Sub-module arb_watchdog: TIMEOUT-parameterised counter, inputs clr/en, output expired.

## Test plan
- Fetch only, m_ready tied 1: if_req cycle 0, if_addr 0x100, m_rdata 0x00500093 → m_req cycle 1, if_ack + if_instr 0x00500093 cycle 2, stall_if high cycles 0–1.
- Simultaneous d_rd (0x200) and if_req (0x104): DATA served first, d_ack cycle 2, FETCH m_req cycle 2 with no IDLE bubble, if_ack cycle 3.
- Store d_wr addr 0x300, wdata 0xDEADBEEF, be 4'b0011, m_ready after 3 waits → m_we=1, fields stable 4 cycles, d_ack cycle 5, d_rdata unchanged.
- m_ready never asserted, TIMEOUT=4, fetch → bus_err + if_ack cycle 6, if_instr 0x00000013.
- rst asserted while DATA busy with m_ready low → m_req low same cycle, no d_ack, IDLE after release.
